// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg : shared RV32I ALU encodings.
//   - funct3 codes for the OP / OP-IMM groups
//   - ctrl codes understood by the shared alu
//   - decode(): {funct3, funct7[5], is_imm} -> {alu ctrl, use_cmp, cmp_unsigned}
// ---------------------------------------------------------------------------
package rv32i_pkg;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLL = 3'b101;
   localparam logic [2:0] ALU_SRL = 3'b110;
   localparam logic [2:0] ALU_SRA = 3'b111;

   typedef struct packed {
      logic [2:0] ctrl;
      logic       use_cmp;       // result comes from the in-stage comparator
      logic       cmp_unsigned;  // SLTU rather than SLT
   } dec_t;

   function automatic dec_t decode(input logic [2:0] f3, input logic alt,
                                   input logic is_imm);
      dec_t d;
      d = '{ctrl: ALU_ADD, use_cmp: 1'b0, cmp_unsigned: 1'b0};
      case (f3)
         // ADDI has no SUB form: bit 30 of its immediate is data, not alt
         F3_ADD:  d.ctrl = (alt && !is_imm) ? ALU_SUB : ALU_ADD;
         F3_SLL:  d.ctrl = ALU_SLL;
         F3_SLT:  d.use_cmp = 1'b1;
         F3_SLTU: begin d.use_cmp = 1'b1; d.cmp_unsigned = 1'b1; end
         F3_XOR:  d.ctrl = ALU_XOR;
         // SRAI keeps bit 30 set in its encoding, so alt selects for both forms
         F3_SR:   d.ctrl = alt ? ALU_SRA : ALU_SRL;
         F3_OR:   d.ctrl = ALU_OR;
         default: d.ctrl = ALU_AND;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu : shared combinational ALU.
//   i_ctrl   [2:0]          operation (ALU_* codes from rv32i_pkg)
//   i_a      [data_width]   first operand
//   i_b      [data_width]   second operand; low $clog2(data_width) bits are
//                           the shift amount for shift ops
//   o_result [data_width]   result, add/sub wrap modulo 2^data_width
// ---------------------------------------------------------------------------
module alu
   import rv32i_pkg::*;
#(
   parameter int data_width = 32
) (
   input  logic [2:0]            i_ctrl,
   input  logic [data_width-1:0] i_a,
   input  logic [data_width-1:0] i_b,
   output logic [data_width-1:0] o_result
);

   localparam int SW = $clog2(data_width);

   logic [SW-1:0] w_shamt;
   assign w_shamt = i_b[SW-1:0];

   always_comb begin
      o_result = '0;
      case (i_ctrl)
         ALU_ADD: o_result = i_a + i_b;
         ALU_SUB: o_result = i_a - i_b;
         ALU_AND: o_result = i_a & i_b;
         ALU_OR:  o_result = i_a | i_b;
         ALU_XOR: o_result = i_a ^ i_b;
         ALU_SLL: o_result = i_a << w_shamt;
         ALU_SRL: o_result = i_a >> w_shamt;
         default: o_result = $signed(i_a) >>> w_shamt;
      endcase
   end

endmodule

// File: rtl/ex_alu_stage.sv
// ---------------------------------------------------------------------------
// ex_alu_stage : RV32I execute stage feeding register-file writeback.
//   clk, rst_n          clock, async active-low reset
//   flush               sync; drops all buffered results
//   in_valid/in_ready   accept handshake (in_ready from registered count only)
//   in_funct3, in_alt, in_is_imm   decoded operation
//   in_a, in_b, in_tag  operands and destination register
//   out_valid/out_ready result handshake
//   out_result, out_tag head of the 2-entry result buffer
// Result is computed at accept and written into the buffer, so it is
// visible the cycle after acceptance.
// ---------------------------------------------------------------------------
module ex_alu_stage
   import rv32i_pkg::*;
#(
   parameter int data_width = 32,
   parameter int tag_width  = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            in_funct3,
   input  logic                  in_alt,
   input  logic                  in_is_imm,
   input  logic [data_width-1:0] in_a,
   input  logic [data_width-1:0] in_b,
   input  logic [tag_width-1:0]  in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [data_width-1:0] out_result,
   output logic [tag_width-1:0]  out_tag
);

   localparam int SW = $clog2(data_width);

   dec_t                  w_dec;
   logic                  w_is_shift;
   logic [data_width-1:0] w_alu_b;
   logic [data_width-1:0] w_alu_res;
   logic                  w_lt;
   logic [data_width-1:0] w_res;
   logic                  w_accept;
   logic                  w_pop;

   logic [data_width-1:0] r_res [2];
   logic [tag_width-1:0]  r_tag [2];
   logic                  r_wr_ptr;
   logic                  r_rd_ptr;
   logic [1:0]            r_count;

   assign w_dec      = decode(in_funct3, in_alt, in_is_imm);
   assign w_is_shift = (w_dec.ctrl == ALU_SLL) || (w_dec.ctrl == ALU_SRL) ||
                       (w_dec.ctrl == ALU_SRA);
   // shifts see only the shamt field so upper immediate bits cannot leak in
   assign w_alu_b    = w_is_shift ? data_width'(in_b[SW-1:0]) : in_b;

   alu #(.data_width(data_width)) u_alu (
      .i_ctrl   (w_dec.ctrl),
      .i_a      (in_a),
      .i_b      (w_alu_b),
      .o_result (w_alu_res)
   );

   assign w_lt  = w_dec.cmp_unsigned ? (in_a < in_b)
                                     : ($signed(in_a) < $signed(in_b));
   assign w_res = w_dec.use_cmp ? data_width'(w_lt) : w_alu_res;

   assign in_ready   = (r_count != 2'd2);
   assign out_valid  = (r_count != 2'd0);
   assign out_result = r_res[r_rd_ptr];
   assign out_tag    = r_tag[r_rd_ptr];

   assign w_accept = in_valid && in_ready;
   assign w_pop    = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            r_res[i] <= '0;
            r_tag[i] <= '0;
         end
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (flush) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_accept) begin
            r_res[r_wr_ptr] <= w_res;
            r_tag[r_wr_ptr] <= in_tag;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_alu_stage.sv
module tb_ex_alu_stage;

   localparam int DW = 32;
   localparam int TW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic [2:0]    in_funct3 = '0;
   logic          in_alt = 1'b0;
   logic          in_is_imm = 1'b0;
   logic [DW-1:0] in_a = '0;
   logic [DW-1:0] in_b = '0;
   logic [TW-1:0] in_tag = '0;
   logic          out_ready = 1'b0;
   logic          in_ready, out_valid;
   logic [DW-1:0] out_result;
   logic [TW-1:0] out_tag;

   // 16-bit instance for shamt masking
   logic          h_valid = 1'b0;
   logic [2:0]    h_f3 = '0;
   logic          h_alt = 1'b0;
   logic [15:0]   h_a = '0;
   logic [15:0]   h_b = '0;
   logic          h_in_ready, h_out_valid;
   logic [15:0]   h_res;
   logic [TW-1:0] h_tag;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [DW-1:0] res;
      logic [TW-1:0] tag;
   } exp_t;
   exp_t          sb[$];
   logic [DW-1:0] cur_exp = '0;

   always #5 clk = ~clk;

   ex_alu_stage #(.data_width(DW), .tag_width(TW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_funct3(in_funct3), .in_alt(in_alt), .in_is_imm(in_is_imm),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag)
   );

   ex_alu_stage #(.data_width(16), .tag_width(TW)) dut16 (
      .clk(clk), .rst_n(rst_n), .flush(1'b0),
      .in_valid(h_valid), .in_ready(h_in_ready),
      .in_funct3(h_f3), .in_alt(h_alt), .in_is_imm(1'b0),
      .in_a(h_a), .in_b(h_b), .in_tag(5'd0),
      .out_valid(h_out_valid), .out_ready(1'b1),
      .out_result(h_res), .out_tag(h_tag)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] f3, input logic alt,
                                         input logic imm, input logic [31:0] a,
                                         input logic [31:0] b);
      case (f3)
         3'd0:    return (alt && !imm) ? a - b : a + b;
         3'd1:    return a << b[4:0];
         3'd2:    return {31'b0, $signed(a) < $signed(b)};
         3'd3:    return {31'b0, a < b};
         3'd4:    return a ^ b;
         3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'd6:    return a | b;
         default: return a & b;
      endcase
   endfunction

   // scoreboard: inputs change at posedge+1, sample here at negedge
   always @(negedge clk) begin
      if (!rst_n || flush) sb.delete();
      else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("spurious_out", out_valid, 1'b0);
            else begin
               chk("result", out_result, sb[0].res);
               chk("tag", 32'(out_tag), 32'(sb[0].tag));
               void'(sb.pop_front());
            end
         end
         if (in_valid && in_ready) sb.push_back('{cur_exp, in_tag});
      end
   end

   task automatic send(input logic [2:0] f3, input logic alt, input logic imm,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp);
      bit ok = 1'b0;
      in_funct3 = f3; in_alt = alt; in_is_imm = imm;
      in_a = a; in_b = b; in_tag = tag; cur_exp = exp; in_valid = 1'b1;
      for (int n = 0; n < 50 && !ok; n++) begin
         ok = in_ready;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("accept", 32'(ok), 1);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int n = 0; n < 50 && sb.size() != 0; n++) begin
         @(posedge clk); #1;
      end
      chk("drained", sb.size(), 0);
   endtask

   task automatic h_op(input logic [2:0] f3, input logic alt, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp);
      h_f3 = f3; h_alt = alt; h_a = a; h_b = b; h_valid = 1'b1;
      @(posedge clk); #1;
      h_valid = 1'b0;
      chk("w16_valid", 32'(h_out_valid), 1);
      chk("w16_result", 32'(h_res), 32'(exp));
   endtask

   initial begin
      #22;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_result", out_result, 0);
      chk("rst_out_tag", 32'(out_tag), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // basic add and one-cycle latency
      out_ready = 1'b1;
      send(3'd0, 0, 0, 5, 4, 3, 9);
      chk("add_valid", 32'(out_valid), 1);
      chk("add_result", out_result, 9);
      chk("add_tag", 32'(out_tag), 3);
      @(posedge clk); #1;
      chk("add_empty_after", 32'(out_valid), 0);

      // sub vs addi, compares, shifts
      send(3'd0, 1, 0, 13, 66, 4, 32'hFFFFFFCB);
      send(3'd0, 1, 1, 13, 66, 5, 79);
      send(3'd2, 0, 0, 32'hFFFFFFB3, 5, 6, 1);
      send(3'd3, 0, 0, 32'hFFFFFFB3, 5, 7, 0);
      send(3'd5, 1, 0, 32'hFFFFFE70, 2, 8, 32'hFFFFFF9C);
      send(3'd5, 0, 0, 32'hFFFFFE70, 2, 9, 32'h3FFFFF9C);
      send(3'd1, 0, 0, 1, 37, 10, 32);
      send(3'd5, 0, 1, 32'h80000000, 33, 11, 32'h40000000);
      send(3'd5, 1, 1, 32'h80000000, 33, 12, 32'hC0000000);
      drain();

      // backpressure: third op held until a slot frees
      out_ready = 1'b0;
      send(3'd0, 0, 0, 1, 1, 1, 2);
      send(3'd0, 0, 0, 2, 2, 2, 4);
      in_funct3 = 3'd0; in_alt = 0; in_is_imm = 0;
      in_a = 3; in_b = 3; in_tag = 3; cur_exp = 6; in_valid = 1'b1;
      chk("bp_full_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
      chk("bp_held_ready", 32'(in_ready), 0);
      chk("bp_held_valid", 32'(out_valid), 1);
      out_ready = 1'b1;
      send(3'd0, 0, 0, 3, 3, 3, 6);
      drain();
      chk("bp_ready_back", 32'(in_ready), 1);
      chk("bp_empty", 32'(out_valid), 0);

      // flush with simultaneous accept
      out_ready = 1'b0;
      send(3'd4, 0, 0, 32'hF0F0, 32'h0FF0, 13, 32'hFF00);
      send(3'd6, 0, 0, 32'hF000, 32'h000F, 14, 32'hF00F);
      in_funct3 = 3'd7; in_a = 32'hFF; in_b = 32'h0F; in_tag = 15; in_valid = 1'b1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_valid", 32'(out_valid), 0);
      chk("flush_ready", 32'(in_ready), 1);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("flush_not_stored", 32'(out_valid), 0);

      // async reset between edges
      out_ready = 1'b0;
      send(3'd0, 0, 0, 7, 8, 16, 15);
      chk("pre_rst_valid", 32'(out_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 0);
      chk("async_rst_ready", 32'(in_ready), 1);
      @(posedge clk); #3;
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_idle", 32'(out_valid), 0);

      // random traffic against the reference model
      for (int i = 0; i < 40; i++) begin
         logic [2:0]  f3;
         logic        alt, imm;
         logic [31:0] a, b;
         f3 = 3'($urandom_range(0, 7));
         alt = 1'($urandom_range(0, 1));
         imm = 1'($urandom_range(0, 1));
         a = $urandom;
         b = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         if (!in_ready) out_ready = 1'b1;
         send(f3, alt, imm, a, b, 5'(i), model(f3, alt, imm, a, b));
      end
      drain();

      // 16-bit width: shamt masked to 4 bits
      h_op(3'd1, 0, 16'h0001, 16'd17, 16'h0002);
      h_op(3'd5, 0, 16'h8000, 16'h0013, 16'h1000);
      h_op(3'd5, 1, 16'h8000, 16'h0023, 16'hF000);
      h_op(3'd0, 1, 16'h0003, 16'h0005, 16'hFFFE);

      repeat (2) @(posedge clk);
      chk("sb_final_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule

// File: doc/ex_alu_stage.md
Name: ex_alu_stage

Overview:
- Execute pipeline stage sitting directly upstream of the register-file writeback. It wraps the shared `alu`.
- Accepts decoded RV32I ALU operations (funct3/funct7[5]/immediate flag plus two operands) over a valid/ready handshake.
- Maps each operation onto the 3-bit `alu` ctrl code, or onto an in-stage comparator for SLT/SLTU.
- Registers the result with its destination tag into a 2-entry output buffer, so `in_ready` never depends combinationally on `out_ready`.

Parameters:
- data_width, 32, operand/result width; must be a power of two, at least 8.
- tag_width, 5, width of destination-register tag carried alongside the result.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; discards all buffered results.
- in_valid  in  1  upstream offers an operation.
- in_ready  out  1  stage can accept this cycle.
- in_funct3  in  3  RV32I funct3.
- in_alt  in  1  RV32I funct7[5].
- in_is_imm  in  1  1 = OP-IMM form, 0 = OP form.
- in_a  in  data_width  rs1 value.
- in_b  in  data_width  rs2 value or sign-extended immediate.
- in_tag  in  tag_width  destination register index.
- out_valid  out  1  head result available.
- out_ready  in  1  downstream consumes head.
- out_result  out  data_width  head result.
- out_tag  out  tag_width  head tag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - count=0, out_valid=0, in_ready=1, out_result=0, out_tag=0, both buffer entries cleared.
  - Reset asserted mid-transfer drops all data.
- Handshakes:
  - Accept on the rising edge where in_valid&&in_ready.
  - Pop on the rising edge where out_valid&&out_ready.
  - in_ready = (count!=2), derived from registered count only.
  - out_valid = (count!=0).
- Latency:
  - Result of an operation accepted at edge N is on out_result/out_tag from edge N (visible the cycle after acceptance).
  - Throughput is 1/cycle when out_ready is held high.
- Operation decode (computed combinationally on the accept side, stored in the buffer):
  - 000: add → alu ctrl 000; if !in_is_imm && in_alt → sub, ctrl 001. ADDI ignores in_alt.
  - 001: sll → ctrl 101.
  - 010: slt → {0…,($signed a < $signed b)}; the alu is not used.
  - 011: sltu → {0…,(a < b unsigned)}.
  - 100: xor → ctrl 100.
  - 101: in_alt ? sra (ctrl 111) : srl (ctrl 110); in_alt is honoured for both imm and reg forms.
  - 110: or → ctrl 011.
  - 111: and → ctrl 010.
- Shift amount:
  - The b fed to the alu for ctrl 101/110/111 is zero-extended b[$clog2(data_width)-1:0]; upper bits of b are ignored.
  - Example: b=33 with data_width 32 shifts by 1.
- Arithmetic:
  - add/sub wrap modulo 2^data_width.
  - No overflow flag.
- Buffer: 2-entry circular FIFO with rd_ptr, wr_ptr, count 0..2.
  - Simultaneous accept and pop when count=1 or count=2: count unchanged. When count=2 no accept occurs, since in_ready=0.
  - Simultaneous accept and pop when count=0 cannot happen, because out_valid=0.
  - When empty, out_result/out_tag hold their last values and are don't-care while out_valid=0.
- flush:
  - At the edge, count:=0 and pointers reset.
  - Any simultaneous accept is discarded and any simultaneous pop does not occur.
  - in_ready=1 on the next cycle.
- Unsupported encodings: none; every funct3/alt/imm combination produces a defined result.

Decomposition:
- Shared package `rv32i_pkg`:
  - funct3 localparams (F3_ADD … F3_AND).
  - alu ctrl localparams (ALU_ADD=3'b000 … ALU_SRA=3'b111).
  - A decode function mapping {funct3, alt, is_imm} to {ctrl, use_cmp, cmp_unsigned}.
- One sub-module: the existing `alu`, instantiated with data_width passed through.
- The buffer stays inline; it is not worth a separate module at 2 entries.

Test Plan:
- Reset and basic add:
  - Stimulus: after reset, out_valid=0 and in_ready=1. Then accept funct3=000, alt=0, a=5, b=4, tag=3 with out_ready=1.
  - Response: next cycle out_valid=1, out_result=9, out_tag=3; the cycle after that, out_valid=0.
- Sub vs addi:
  - Stimulus: funct3=000, alt=1, is_imm=0, a=13, b=66.
  - Response: result 32'hFFFFFFCB (−53). The same with is_imm=1 gives 79.
- Compare and shift:
  - slt a=−77, b=5 → 1; sltu a=−77, b=5 → 0.
  - sra a=−400, b=2 → −100; srl a=−400, b=2 → 32'h3FFFFF9C.
  - sll a=1, b=37 → 32 (shift by 5).
- Backpressure:
  - Stimulus: out_ready=0 while issuing 3 back-to-back operations (add 1+1, 2+2, 3+3).
  - Response: the first two are accepted, then in_ready=0 and the third is held.
  - Then raise out_ready: results pop in order 2, 4, 6 with no loss, and in_ready returns to 1.
- Flush with simultaneous accept:
  - Stimulus: count=2, assert flush with in_valid=1.
  - Response: next cycle out_valid=0, in_ready=1, and the offered operation is not stored.
- Async reset mid-stream:
  - Stimulus: deassert rst_n between clock edges with count=1.
  - Response: out_valid falls immediately (no clock needed) and the stage stays idle after release.
- Also run with data_width=16 to confirm shamt is masked to 4 bits.
